instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, meaning instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning the PC loaded on reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_in  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n_in  input  1  reset; asynchronous, active-low.
REQ-006 rdy_in  input  1  pause; when low, all state holds.
REQ-007 clear_signal  input  1  misprediction flush request.
REQ-008 clear_pc  input  32  correct PC after a flush.
REQ-009 fetch_signal  output  1  fetch request to the instruction cache.
REQ-010 fetch_addr  output  32  fetch address, equal to the current PC.
REQ-011 fetch_done  input  1  cache hit, combinational in the same cycle.
REQ-012 fetch_instr  input  32  instruction word, valid when fetch_done=1.
REQ-013 iq_valid  output  1  queue head valid for the decoder.
REQ-014 iq_instr  output  32  head instruction.
REQ-015 iq_pc  output  32  head instruction PC.
REQ-016 iq_pred_jump  output  1  head was predicted taken (JAL or taken branch).
REQ-017 iq_ready  input  1  decoder pops the head this cycle.

Function
REQ-018 SHALL implement two states: FETCH and STALL.
REQ-019 SHALL drive fetch_signal = (state==FETCH) & (count<IQ_DEPTH) as combinational logic, and drive fetch_addr = pc as a register.
REQ-020 SHALL accept an instruction exactly when rdy_in & ~clear_signal & fetch_signal & fetch_done.
  - On accept, it pushes {fetch_instr, pc, pred} at the tail.
REQ-021 SHALL compute the next PC on accept as follows:
  - opcode 1101111 (JAL): pc + sext({i[31],i[19:12],i[20],i[30:21],0}); pred=1.
  - opcode 1100011 (branch): if i[31]=1 (backward), pc + sext({i[31],i[7],i[30:25],i[11:8],0}) with pred=1; else pc+4 with pred=0.
  - opcode 1100111 (JALR): pc+4, pred=0, and state->STALL.
  - otherwise: pc+4, pred=0.
REQ-022 SHALL wrap all PC arithmetic modulo 2^32.
REQ-023 SHALL, in STALL, issue no fetches and remain in STALL until a clear occurs.
REQ-024 SHALL pop the head when rdy_in & ~clear_signal & iq_valid & iq_ready; iq_valid = (count!=0).
REQ-025 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
  - Push is impossible when full because fetch_signal is low.
REQ-026 SHALL use wrap-around head/tail pointers modulo IQ_DEPTH and a count of width log2(IQ_DEPTH)+1.
REQ-027 SHALL give clear_signal (with rdy_in=1) priority over push and pop in the same cycle:
  - count<=0, head<=tail<=0, pc<=clear_pc, state<=FETCH.
  - fetch_done in that cycle is ignored.
REQ-028 SHALL fetch from clear_pc in the first cycle after a clear.
REQ-029 SHALL hold pc, queue, pointers and state while rdy_in=0, including when clear_signal=1.
  - Outputs still reflect the held state.
REQ-030 SHALL drive iq_instr, iq_pc and iq_pred_jump from the head entry; their values are don't-care when iq_valid=0.

Reset
REQ-031 SHALL, while rst_n_in=0, force pc=RESET_PC, state=FETCH, count=0 and head=tail=0.
  - Resulting outputs: fetch_addr=RESET_PC, fetch_signal=1, iq_valid=0.
REQ-032 SHALL, on reset asserted mid-operation, discard all queued instructions immediately.
  - It discards them without waiting for a clock edge.
REQ-033 SHALL NOT reset queue storage contents.

Verification
REQ-034 SHALL cover straight-line fetch:
  - Stimulus: reset, fetch_done=1 with ADDI words, iq_ready=0.
  - Response: iq_pc 0,4,8,12 queued; fetch_signal=0 after 4 accepts; count=4.
REQ-035 SHALL cover JAL redirect:
  - Stimulus: word 0x0100006F at pc=0x0.
  - Response: next fetch_addr=0x10; queued entry has iq_pred_jump=1.
REQ-036 SHALL cover backward branch:
  - Stimulus: BEQ word 0xFE000EE3 at pc=0x20.
  - Response: next fetch_addr=0x1C; pred=1. The forward-branch variant gives 0x24 with pred=0.
REQ-037 SHALL cover the JALR stall:
  - Stimulus: JALR at pc=0x8.
  - Response: fetch_signal=0 until clear_signal with clear_pc=0x100; the next cycle gives fetch_addr=0x100 and fetch_signal=1.
REQ-038 SHALL cover flush with simultaneous events:
  - Stimulus: queue holds 3 entries; clear_signal, fetch_done and iq_ready all asserted in one cycle.
  - Response: the next cycle gives iq_valid=0 and fetch_addr=clear_pc.
REQ-039 SHALL cover rdy and async reset:
  - Stimulus: rdy_in=0 for 5 cycles with fetch_done=1.
  - Response: no state change.
  - Stimulus: rst_n_in pulsed low mid-cycle.
  - Response: iq_valid=0 and fetch_addr=RESET_PC before the next edge.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation with static branch prediction
// and a circular instruction queue toward the decoder.
module instr_fetch #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic [31:0] clear_pc,
  output logic        fetch_signal,
  output logic [31:0] fetch_addr,
  input  logic        fetch_done,
  input  logic [31:0] fetch_instr,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic        iq_pred_jump,
  input  logic        iq_ready
);

  localparam int unsigned PW = $clog2(IQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  typedef enum logic {FETCH, STALL} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  state_t          state, state_nxt;
  logic [31:0]     pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head, tail;
  iq_entry_t       iq_mem [IQ_DEPTH];

  logic [31:0]     next_pc;
  logic [31:0]     imm_j, imm_b;
  logic            pred;
  logic            is_jalr;
  logic            accept;
  logic            pop;
  iq_entry_t       head_entry;

  assign fetch_addr = pc;
  assign accept = rdy_in & ~clear_signal & fetch_signal & fetch_done;
  assign pop    = rdy_in & ~clear_signal & iq_valid & iq_ready;

  // Static prediction: JAL and backward branches are taken, JALR waits for a redirect.
  always_comb begin
    imm_j   = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
               fetch_instr[20], fetch_instr[30:21], 1'b0};
    imm_b   = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
               fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    next_pc = pc + 32'd4;
    pred    = 1'b0;
    is_jalr = 1'b0;
    case (fetch_instr[6:0])
      7'b1101111: begin
        next_pc = pc + imm_j;
        pred    = 1'b1;
      end
      7'b1100011: begin
        if (fetch_instr[31]) begin
          next_pc = pc + imm_b;
          pred    = 1'b1;
        end
      end
      7'b1100111: is_jalr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= FETCH;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rdy_in && clear_signal)  state_nxt = FETCH;
    else if (accept && is_jalr)  state_nxt = STALL;
  end

  always_comb begin
    head_entry   = iq_mem[head];
    fetch_signal = (state == FETCH) && (count < DEPTH_C);
    iq_valid     = (count != '0);
    iq_instr     = head_entry.instr;
    iq_pc        = head_entry.pc;
    iq_pred_jump = head_entry.pred;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        pc    <= clear_pc;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (accept) begin
          pc   <= next_pc;
          tail <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
        case ({accept, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk_in) begin
    if (accept) iq_mem[tail] <= {fetch_instr, pc, pred};
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: one-cycle vectors with expected
// post-edge outputs, plus hand-written reset sequences.
module tb_instr_fetch;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_signal;
  logic [31:0] clear_pc;
  logic        fetch_signal;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_instr;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_pred_jump;
  logic        iq_ready;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  instr_fetch #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .clear_signal(clear_signal), .clear_pc(clear_pc),
    .fetch_signal(fetch_signal), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_instr(fetch_instr),
    .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .iq_pred_jump(iq_pred_jump), .iq_ready(iq_ready)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [31:0] A0 = 32'h00100093, A1 = 32'h00200113,
                          A2 = 32'h00300193, A3 = 32'h00400213,
                          A4 = 32'h00500293, JAL = 32'h0100006F,
                          JALN = 32'hFF9FF06F, BEQB = 32'hFE000EE3,
                          BEQF = 32'h00000463, JALR = 32'h00008067;

  typedef struct {
    logic        rdy, clr;
    logic [31:0] cpc;
    logic        done;
    logic [31:0] instr;
    logic        pop;
    logic        e_fs;
    logic [31:0] e_fa;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_pred;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic clr, input logic [31:0] cpc,
                     input logic done, input logic [31:0] instr, input logic pop,
                     input logic fs, input logic [31:0] fa, input logic v,
                     input logic [31:0] pc, input logic pred, input logic [31:0] ins);
    vec_t t;
    t = '{rdy, clr, cpc, done, instr, pop, fs, fa, v, pc, pred, ins};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(negedge clk_in);
    rdy_in = t.rdy; clear_signal = t.clr; clear_pc = t.cpc;
    fetch_done = t.done; fetch_instr = t.instr; iq_ready = t.pop;
    @(posedge clk_in);
    #1;
    chk($sformatf("v%0d fetch_signal", idx), 32'(fetch_signal), 32'(t.e_fs));
    chk($sformatf("v%0d fetch_addr", idx), fetch_addr, t.e_fa);
    chk($sformatf("v%0d iq_valid", idx), 32'(iq_valid), 32'(t.e_v));
    if (t.e_v) begin
      chk($sformatf("v%0d iq_pc", idx), iq_pc, t.e_pc);
      chk($sformatf("v%0d iq_pred_jump", idx), 32'(iq_pred_jump), 32'(t.e_pred));
      chk($sformatf("v%0d iq_instr", idx), iq_instr, t.e_ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; clear_pc = '0;
    fetch_done = 1'b0; fetch_instr = '0; iq_ready = 1'b0;

    // straight-line fill, then drain with simultaneous push/pop
    add(1,0,0,1,A0,0,  1,32'h4,1,32'h0,0,A0);
    add(1,0,0,1,A1,0,  1,32'h8,1,32'h0,0,A0);
    add(1,0,0,1,A2,0,  1,32'hC,1,32'h0,0,A0);
    add(1,0,0,1,A3,0,  0,32'h10,1,32'h0,0,A0);
    add(1,0,0,1,JAL,0, 0,32'h10,1,32'h0,0,A0);
    add(1,0,0,0,A4,1,  1,32'h10,1,32'h4,0,A1);
    add(1,0,0,1,A4,1,  1,32'h14,1,32'h8,0,A2);
    add(1,0,0,0,A4,1,  1,32'h14,1,32'hC,0,A3);
    add(1,0,0,0,A4,1,  1,32'h14,1,32'h10,0,A4);
    add(1,0,0,0,A4,1,  1,32'h14,0,0,0,0);
    // JAL, branches, PC wrap
    add(1,1,32'h0,0,0,1,     1,32'h0,0,0,0,0);
    add(1,0,0,1,JAL,0,       1,32'h10,1,32'h0,1,JAL);
    add(1,0,0,0,0,1,         1,32'h10,0,0,0,0);
    add(1,1,32'h20,0,0,0,    1,32'h20,0,0,0,0);
    add(1,0,0,1,BEQB,0,      1,32'h1C,1,32'h20,1,BEQB);
    add(1,1,32'h20,0,0,1,    1,32'h20,0,0,0,0);
    add(1,0,0,1,BEQF,0,      1,32'h24,1,32'h20,0,BEQF);
    add(1,1,32'h0,0,0,1,     1,32'h0,0,0,0,0);
    add(1,0,0,1,JALN,0,      1,32'hFFFFFFF8,1,32'h0,1,JALN);
    add(1,1,32'hFFFFFFFC,0,0,1, 1,32'hFFFFFFFC,0,0,0,0);
    add(1,0,0,1,A0,0,        1,32'h0,1,32'hFFFFFFFC,0,A0);
    // JALR stall until redirect
    add(1,1,32'h8,0,0,1,     1,32'h8,0,0,0,0);
    add(1,0,0,1,JALR,0,      0,32'hC,1,32'h8,0,JALR);
    add(1,0,0,1,A1,0,        0,32'hC,1,32'h8,0,JALR);
    add(1,0,0,1,A1,0,        0,32'hC,1,32'h8,0,JALR);
    add(1,1,32'h100,1,A1,0,  1,32'h100,0,0,0,0);
    add(1,0,0,1,A1,0,        1,32'h104,1,32'h100,0,A1);
    add(1,0,0,1,A2,0,        1,32'h108,1,32'h100,0,A1);
    add(1,0,0,1,A3,0,        1,32'h10C,1,32'h100,0,A1);
    // flush with fetch_done and pop in the same cycle
    add(1,1,32'h200,1,JAL,1, 1,32'h200,0,0,0,0);
    add(1,0,0,1,A2,0,        1,32'h204,1,32'h200,0,A2);
    // rdy_in low holds everything, even with a clear request
    add(0,0,0,1,JAL,1,       1,32'h204,1,32'h200,0,A2);
    add(0,0,0,1,JAL,1,       1,32'h204,1,32'h200,0,A2);
    add(0,1,32'h300,1,JAL,1, 1,32'h204,1,32'h200,0,A2);
    add(0,0,0,1,JAL,1,       1,32'h204,1,32'h200,0,A2);
    add(0,0,0,1,JAL,1,       1,32'h204,1,32'h200,0,A2);
    add(1,0,0,0,0,0,         1,32'h204,1,32'h200,0,A2);

    // reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset fetch_signal", 32'(fetch_signal), 32'd1);
    chk("reset fetch_addr", fetch_addr, 32'h0);
    chk("reset iq_valid", 32'(iq_valid), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // asynchronous reset mid-cycle with one entry queued
    @(negedge clk_in);
    rdy_in = 1'b1; clear_signal = 1'b0; fetch_done = 1'b0; iq_ready = 1'b0;
    @(posedge clk_in);
    #2;
    chk("pre-areset iq_valid", 32'(iq_valid), 32'd1);
    rst_n_in = 1'b0;
    #1;
    chk("areset iq_valid", 32'(iq_valid), 32'd0);
    chk("areset fetch_addr", fetch_addr, 32'h0);
    chk("areset fetch_signal", 32'(fetch_signal), 32'd1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    begin
      vec_t t;
      t = '{1'b1, 1'b0, 32'h0, 1'b1, A3, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, A3};
      apply(999, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
